// File: rtl/rs_syn_stream_if.sv
// Stream bundle for rs_syn_stream: symbol input channel and syndrome output channel.
// master = symbol source / result consumer, slave = syndrome engine.
interface rs_syn_stream_if #(
   parameter int unsigned NSYM = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              in_last;
   logic [7:0]        in_n;
   logic              syn_valid;
   logic              syn_ready;
   logic [NSYM*8-1:0] syn_data;
   logic              syn_nz;
   logic              syn_len_err;

   modport master (
      output in_valid, in_data, in_last, in_n, syn_ready,
      input  in_ready, syn_valid, syn_data, syn_nz, syn_len_err
   );

   modport slave (
      input  in_valid, in_data, in_last, in_n, syn_ready,
      output in_ready, syn_valid, syn_data, syn_nz, syn_len_err
   );
endinterface

// File: rtl/rs_syn_stream.sv
// Streaming Reed-Solomon syndrome engine over GF(2^8).
// Symbols arrive highest-degree first; each accumulator runs Horner's rule at alpha^(FCR+i).
// A one-deep output slot lets the next codeword accumulate while a result waits.
// Optional length check: define RS_SYN_LEN_CHECK_EN to enable in_n/counter-based syn_len_err;
// otherwise syn_len_err is tied to 0 and codewords are delimited by in_last only.
module rs_syn_stream #(
   parameter int unsigned NSYM      = 32,
   parameter int unsigned FCR       = 0,
   parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
   input logic             clk,
   input logic             rst,
   rs_syn_stream_if.slave  bus
);

   typedef enum logic [1:0] {StEmpty, StFull, StPend} slot_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
      end
      return p;
   endfunction

   // Evaluation points alpha^(FCR+i), fixed at elaboration.
   function automatic logic [NSYM*8-1:0] gen_roots();
      logic [NSYM*8-1:0] r;
      logic [7:0]        p;
      r = '0;
      p = 8'h01;
      for (int unsigned k = 0; k < FCR; k++) p = gf_mul(p, 8'h02);
      for (int unsigned i = 0; i < NSYM; i++) begin
         r[8*i +: 8] = p;
         p = gf_mul(p, 8'h02);
      end
      return r;
   endfunction

   localparam logic [NSYM*8-1:0] ROOTS = gen_roots();

   logic [NSYM-1:0][7:0] acc_q, acc_d;
   logic                 first_q;
   logic                 err_d;
   logic                 in_xfer, out_xfer, done;

   slot_state_e          state_q;
   logic                 syn_valid_q, in_ready_q;
   logic [NSYM*8-1:0]    slot_q;
   logic                 nz_q, err_q, pend_err_q;

   assign in_xfer  = bus.in_valid & in_ready_q;
   assign out_xfer = syn_valid_q & bus.syn_ready;
   assign done     = in_xfer & bus.in_last;

   assign bus.in_ready    = in_ready_q;
   assign bus.syn_valid   = syn_valid_q;
   assign bus.syn_data    = slot_q;
   assign bus.syn_nz      = nz_q;
   assign bus.syn_len_err = err_q;

   // Horner step per syndrome; the first symbol of a codeword seeds the accumulator.
   always_comb begin
      acc_d = '0;
      for (int i = 0; i < NSYM; i++) begin
         acc_d[i] = first_q ? bus.in_data
                            : (gf_mul(acc_q[i], ROOTS[8*i +: 8]) ^ bus.in_data);
      end
   end

   // Accumulator and codeword-start flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         first_q <= 1'b1;
      end else if (in_xfer) begin
         acc_q   <= acc_d;
         first_q <= bus.in_last;
      end
   end

`ifdef RS_SYN_LEN_CHECK_EN
   logic [7:0] cnt_q, cnt_d, n_q, n_d;
   logic       sat_q, sat_d;

   // Symbol count after this transfer; sat flags a count that would pass 255.
   always_comb begin
      if (first_q) begin
         cnt_d = 8'd1;
         n_d   = bus.in_n;
         sat_d = 1'b0;
      end else begin
         cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
         n_d   = n_q;
         sat_d = sat_q | (cnt_q == 8'hFF);
      end
      err_d = (n_d == 8'd0) | (cnt_d != n_d) | sat_d;
   end

   // Length-tracking state, advanced only on accepted symbols.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
         n_q   <= 8'd0;
         sat_q <= 1'b0;
      end else if (in_xfer) begin
         cnt_q <= cnt_d;
         n_q   <= n_d;
         sat_q <= sat_d;
      end
   end
`else
   assign err_d = 1'b0;
`endif

   // Output slot FSM; a pending result stays in the accumulator while input is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StEmpty;
         syn_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         slot_q      <= '0;
         nz_q        <= 1'b0;
         err_q       <= 1'b0;
         pend_err_q  <= 1'b0;
      end else begin
         case (state_q)
            StEmpty: begin
               if (done) begin
                  slot_q      <= acc_d;
                  nz_q        <= |acc_d;
                  err_q       <= err_d;
                  syn_valid_q <= 1'b1;
                  state_q     <= StFull;
               end
            end
            StFull: begin
               if (done && out_xfer) begin
                  slot_q <= acc_d;
                  nz_q   <= |acc_d;
                  err_q  <= err_d;
               end else if (done) begin
                  pend_err_q <= err_d;
                  in_ready_q <= 1'b0;
                  state_q    <= StPend;
               end else if (out_xfer) begin
                  syn_valid_q <= 1'b0;
                  state_q     <= StEmpty;
               end
            end
            StPend: begin
               if (out_xfer) begin
                  slot_q     <= acc_q;
                  nz_q       <= |acc_q;
                  err_q      <= pend_err_q;
                  in_ready_q <= 1'b1;
                  state_q    <= StFull;
               end
            end
            default: begin
               syn_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= StEmpty;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs_syn_stream.sv
// Self-checking bench for rs_syn_stream: directed cases plus randomized codewords,
// scored against a log/antilog-table polynomial-evaluation reference model.
module tb_rs_syn_stream;
   localparam int unsigned NSYM = 32;
   localparam int unsigned FCR  = 0;

   typedef logic [7:0] sym_q_t[$];
   typedef struct {
      logic [NSYM*8-1:0] data;
      logic              nz;
      logic              err;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rs_syn_stream_if #(.NSYM(NSYM)) bus ();

   rs_syn_stream #(.NSYM(NSYM), .FCR(FCR), .PRIM_POLY(9'h11D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   res_t              exp_q[$];
   int                tests = 0;
   int                fails = 0;
   int                results_seen = 0;
   logic [NSYM*8-1:0] last_data;
   logic              last_nz, last_err;
   int                exp_t[255];
   int                log_t[256];
   bit                stop_rand;
   bit                c_done;

   task automatic check_vec(input string tag, input logic [NSYM*8-1:0] obs,
                            input logic [NSYM*8-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int gm(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   // S_i = sum_j r_j * alpha^((FCR+i)*(L-1-j)), evaluated term by term.
   function automatic res_t model(input sym_q_t syms, input int n);
      res_t r;
      int   len, s, e;
      len    = syms.size();
      r.data = '0;
      for (int i = 0; i < int'(NSYM); i++) begin
         s = 0;
         e = int'(FCR) + i;
         for (int j = 0; j < len; j++)
            s = s ^ gm(int'(syms[j]), exp_t[(e * (len - 1 - j)) % 255]);
         r.data[8*i +: 8] = s[7:0];
      end
      r.nz = (r.data != '0);
`ifdef RS_SYN_LEN_CHECK_EN
      r.err = (n == 0) || (len != n) || (len > 255);
`else
      r.err = 1'b0;
      if (n < 0) r.err = 1'b0;
`endif
      return r;
   endfunction

   task automatic wait_accept();
      logic rdy;
      int   k;
      k = 0;
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         k++;
      end while (!rdy && k < 2000);
      if (!rdy) check_bit("accept_timeout", rdy, 1'b1);
   endtask

   task automatic send_cw(input sym_q_t syms, input int n, input int gap_pct);
      for (int j = 0; j < syms.size(); j++) begin
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = syms[j];
         bus.in_last  = (j == syms.size() - 1);
         bus.in_n     = n[7:0];
         wait_accept();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      exp_q.push_back(model(syms, n));
   endtask

   task automatic wait_results(input int target);
      int k;
      k = 0;
      while (results_seen < target && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (results_seen < target) check_int("result_timeout", results_seen, target);
   endtask

   task automatic drain();
      int k;
      k = 0;
      bus.syn_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.syn_valid) && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (exp_q.size() != 0) check_int("drain_timeout", exp_q.size(), 0);
   endtask

   function automatic sym_q_t fill(input int len, input logic [7:0] val);
      sym_q_t q;
      q = {};
      for (int j = 0; j < len; j++) q.push_back(val);
      return q;
   endfunction

   function automatic sym_q_t rnd_syms(input int len);
      sym_q_t q;
      q = {};
      for (int j = 0; j < len; j++) q.push_back(8'($urandom_range(255)));
      return q;
   endfunction

   // Output monitor: scores every output transfer and checks hold stability.
   initial begin : monitor
      logic [NSYM*8-1:0] snap;
      bit                have_snap;
      res_t              e;
      have_snap = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            have_snap = 1'b0;
         end else if (bus.syn_valid) begin
            if (have_snap) check_vec("hold_stable", bus.syn_data, snap);
            if (bus.syn_ready) begin
               tests++;
               assert (exp_q.size() != 0) else begin
                  fails++;
                  $error("FAIL unexpected_result: observed %0h expected none", bus.syn_data);
               end
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_vec("syn_data", bus.syn_data, e.data);
                  check_bit("syn_nz", bus.syn_nz, e.nz);
                  check_bit("syn_len_err", bus.syn_len_err, e.err);
               end
               last_data = bus.syn_data;
               last_nz   = bus.syn_nz;
               last_err  = bus.syn_len_err;
               results_seen++;
               have_snap = 1'b0;
            end else begin
               snap      = bus.syn_data;
               have_snap = 1'b1;
            end
         end else begin
            have_snap = 1'b0;
         end
      end
   end

   initial begin : stim
      int     x, base, n, len;
      sym_q_t q;
      res_t   b_exp;
      logic [NSYM*8-1:0] all5;

      x = 1;
      for (int k = 0; k < 255; k++) begin
         exp_t[k] = x;
         log_t[x] = k;
         x = x << 1;
         if (x > 255) x = x ^ 'h11D;
      end

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.in_n      = 8'h00;
      bus.syn_ready = 1'b1;
      stop_rand     = 1'b0;
      c_done        = 1'b0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_bit("rst_syn_valid", bus.syn_valid, 1'b0);
      check_vec("rst_syn_data", bus.syn_data, '0);
      check_bit("rst_syn_nz", bus.syn_nz, 1'b0);
      check_bit("rst_syn_len_err", bus.syn_len_err, 1'b0);
      check_bit("rst_in_ready", bus.in_ready, 1'b1);

      // Zero codeword, full length.
      send_cw(fill(255, 8'h00), 255, 0);
      check_bit("zero_latency", bus.syn_valid, 1'b1);
      wait_results(1);
      check_vec("zero_data", last_data, '0);
      check_bit("zero_nz", last_nz, 1'b0);
      check_bit("zero_err", last_err, 1'b0);

      // Roots check: r(x) = x, so S_i = alpha^i.
      q = {8'h01, 8'h00};
      send_cw(q, 2, 0);
      wait_results(2);
      check_vec("root_s0", NSYM*8'(last_data[7:0]), NSYM*8'(8'h01));
      check_vec("root_s1", NSYM*8'(last_data[15:8]), NSYM*8'(8'h02));
      check_vec("root_s2", NSYM*8'(last_data[23:16]), NSYM*8'(8'h04));
      check_vec("root_s3", NSYM*8'(last_data[31:24]), NSYM*8'(8'h08));
      check_vec("root_s8", NSYM*8'(last_data[71:64]), NSYM*8'(8'h1D));
      check_bit("root_nz", last_nz, 1'b1);

      // Single-symbol codeword.
      send_cw(fill(1, 8'h05), 1, 0);
      check_bit("single_latency", bus.syn_valid, 1'b1);
      wait_results(3);
      all5 = {NSYM{8'h05}};
      check_vec("single_data", last_data, all5);

`ifdef RS_SYN_LEN_CHECK_EN
      base = results_seen;
      send_cw(rnd_syms(8), 10, 0);
      wait_results(base + 1);
      check_bit("len_short_err", last_err, 1'b1);
      send_cw(rnd_syms(10), 10, 0);
      wait_results(base + 2);
      check_bit("len_ok_err", last_err, 1'b0);
      send_cw(rnd_syms(256), 255, 0);
      wait_results(base + 3);
      check_bit("len_sat_err", last_err, 1'b1);
`endif

      // Backpressure: A fills the slot, B goes pending, C stalls.
      drain();
      base = results_seen;
      bus.syn_ready = 1'b0;
      send_cw(rnd_syms(3), 3, 0);
      q = rnd_syms(4);
      b_exp = model(q, 4);
      send_cw(q, 4, 0);
      check_bit("bp_in_ready_low", bus.in_ready, 1'b0);
      check_bit("bp_valid_held", bus.syn_valid, 1'b1);
      fork
         begin
            send_cw(rnd_syms(5), 5, 0);
            c_done = 1'b1;
         end
      join_none
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_bit("bp_c_stalled", bus.in_ready, 1'b0);
      bus.syn_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.syn_ready = 1'b0;
      check_int("bp_a_taken", results_seen, base + 1);
      check_bit("bp_in_ready_back", bus.in_ready, 1'b1);
      check_bit("bp_b_valid", bus.syn_valid, 1'b1);
      check_vec("bp_b_data", bus.syn_data, b_exp.data);
      for (int k = 0; k < 50 && !c_done; k++) begin
         @(posedge clk);
         #1;
      end
      check_bit("bp_c_done", c_done, 1'b1);
      bus.syn_ready = 1'b1;
      wait_results(base + 3);
      repeat (5) @(posedge clk);
      #1;
      check_int("bp_no_dup", results_seen, base + 3);

      // Randomized codewords with random gaps and consumer backpressure.
      fork
         begin
            while (!stop_rand) begin
               @(posedge clk);
               #1;
               bus.syn_ready = 1'($urandom_range(1));
            end
         end
      join_none
      base = results_seen;
      for (int c = 0; c < 25; c++) begin
         len = int'($urandom_range(1, 40));
         n   = len;
`ifdef RS_SYN_LEN_CHECK_EN
         if ($urandom_range(3) == 0) n = int'($urandom_range(255));
`endif
         send_cw(rnd_syms(len), n, (c % 3 == 0) ? 0 : 20);
      end
      stop_rand = 1'b1;
      @(posedge clk);
      #1;
      bus.syn_ready = 1'b1;
      wait_results(base + 25);

      // Reset mid-codeword discards the partial accumulation.
      drain();
      base = results_seen;
      for (int j = 0; j < 100; j++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom_range(1, 255));
         bus.in_last  = 1'b0;
         bus.in_n     = 8'd255;
         wait_accept();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_bit("mid_rst_valid", bus.syn_valid, 1'b0);
      check_bit("mid_rst_ready", bus.in_ready, 1'b1);
      rst = 1'b0;
      send_cw(fill(255, 8'h00), 255, 0);
      wait_results(base + 1);
      repeat (20) @(posedge clk);
      #1;
      check_int("mid_rst_count", results_seen, base + 1);
      check_vec("mid_rst_data", last_data, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
